// File: rtl/palette_share_arbiter.sv
// Two-player palette ROM sharing: round-robin lookup arbitration, registered colour
// result with transparency keying and a per-player frame-counted hit flash.

module palette_flash_cnt #(
  parameter logic [5:0] FLASH_FRAMES = 6'd24
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic i_start,
  input  logic i_tick,
  output logic o_active,
  output logic o_on
);
  logic [5:0] r_cnt;

  // A start pulse beats a same-cycle tick; the count stops at zero.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                     r_cnt <= '0;
    else if (i_start)                 r_cnt <= FLASH_FRAMES;
    else if (i_tick && r_cnt != 6'd0) r_cnt <= r_cnt - 6'd1;
  end

  assign o_active = (r_cnt != 6'd0);
  assign o_on     = o_active && r_cnt[1];
endmodule

module palette_share_arbiter #(
  parameter logic [3:0]  TRANSP_IDX   = 4'd1,
  parameter logic [5:0]  FLASH_FRAMES = 6'd24,
  parameter logic [11:0] FLASH_COLOR  = 12'hFFF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [1:0]  req_valid,
  input  logic [7:0]  req_index,
  output logic [1:0]  req_ready,
  output logic [3:0]  pal_index,
  input  logic [11:0] pal_rgb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_id,
  output logic [11:0] out_rgb,
  output logic        out_transparent,
  input  logic        frame_tick,
  input  logic [1:0]  flash_start,
  output logic [1:0]  flash_active
);
  localparam int NUM_PLAYERS = 2;

  logic        r_rr_last;
  logic        r_out_valid;
  logic        r_out_id;
  logic [11:0] r_out_rgb;
  logic        r_out_transp;

  logic                   w_stall;
  logic [1:0]             w_grant;
  logic                   w_xfer;
  logic                   w_gid;
  logic                   w_transp;
  logic [11:0]            w_rgb;
  logic [NUM_PLAYERS-1:0] w_flash_on;

  genvar g;
  generate
    for (g = 0; g < NUM_PLAYERS; g++) begin : g_flash
      palette_flash_cnt #(.FLASH_FRAMES(FLASH_FRAMES)) u_cnt (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_start (flash_start[g]),
        .i_tick  (frame_tick),
        .o_active(flash_active[g]),
        .o_on    (w_flash_on[g])
      );
    end
  endgenerate

  assign w_stall = r_out_valid && !out_ready;

  always_comb begin
    w_grant = 2'b00;
    if (!w_stall) begin
      case (req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_rr_last ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign req_ready = w_grant;
  assign w_xfer    = |w_grant;
  assign w_gid     = w_grant[1];
  // Idle cycles park the ROM on idx0 so its address stays stable.
  assign pal_index = w_gid ? req_index[7:4] : req_index[3:0];

  assign w_transp = (pal_index == TRANSP_IDX);
  assign w_rgb    = w_transp          ? 12'h000 :
                    w_flash_on[w_gid] ? FLASH_COLOR : pal_rgb;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rr_last    <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_id     <= 1'b0;
      r_out_rgb    <= '0;
      r_out_transp <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_rr_last    <= w_gid;
        r_out_id     <= w_gid;
        r_out_rgb    <= w_rgb;
        r_out_transp <= w_transp;
      end
    end
  end

  assign out_valid       = r_out_valid;
  assign out_id          = r_out_id;
  assign out_rgb         = r_out_rgb;
  assign out_transparent = r_out_transp;
endmodule

// File: tb/tb_palette_share_arbiter.sv
// Directed bench for palette_share_arbiter with a small ROM table and hand-computed results.

module tb_palette_share_arbiter;
  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [1:0]  req_valid;
  logic [7:0]  req_index;
  logic [1:0]  req_ready;
  logic [3:0]  pal_index;
  logic [11:0] pal_rgb;
  logic        out_valid;
  logic        out_ready;
  logic        out_id;
  logic [11:0] out_rgb;
  logic        out_transparent;
  logic        frame_tick;
  logic [1:0]  flash_start;
  logic [1:0]  flash_active;

  int n_chk = 0;
  int n_err = 0;

  logic [11:0] rom [16];
  assign pal_rgb = rom[pal_index];

  always #5 Clk = ~Clk;

  palette_share_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
    .pal_index(pal_index), .pal_rgb(pal_rgb),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_rgb(out_rgb), .out_transparent(out_transparent),
    .frame_tick(frame_tick), .flash_start(flash_start), .flash_active(flash_active)
  );

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk); #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
    end
  endtask

  // One pixel request; checks the grant now and the registered result next cycle.
  task automatic pix(input string tag, input logic [1:0] rv, input logic [3:0] i1,
                     input logic [3:0] i0, input logic [1:0] e_rdy, input logic [3:0] e_idx,
                     input logic e_id, input logic [11:0] e_rgb, input logic e_tr);
    req_valid = rv;
    req_index = {i1, i0};
    #1;
    chk({tag, ".rdy"}, 16'(req_ready), 16'(e_rdy));
    chk({tag, ".idx"}, 16'(pal_index), 16'(e_idx));
    cyc();
    req_valid = 2'b00;
    chk({tag, ".vld"}, 16'(out_valid), 16'd1);
    chk({tag, ".id"},  16'(out_id),    16'(e_id));
    chk({tag, ".rgb"}, 16'(out_rgb),   16'(e_rgb));
    chk({tag, ".tr"},  16'(out_transparent), 16'(e_tr));
  endtask

  initial begin
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    for (int i = 0; i < 16; i++) rom[i] = 12'h0A0;
    rom[5] = 12'hEBA;
    rom[3] = 12'h123;
    rom[1] = 12'hF0F;

    Reset_n = 1'b0; req_valid = 2'b00; req_index = 8'h00; out_ready = 1'b1;
    frame_tick = 1'b0; flash_start = 2'b00;
    #12;
    chk("rst.vld", 16'(out_valid), 16'd0);
    chk("rst.id",  16'(out_id), 16'd0);
    chk("rst.rgb", 16'(out_rgb), 16'h000);
    chk("rst.tr",  16'(out_transparent), 16'd0);
    chk("rst.fa",  16'(flash_active), 16'd0);
    cyc();
    Reset_n = 1'b1;

    // single requesters
    pix("t1", 2'b01, 4'd3, 4'd5, 2'b01, 4'd5, 1'b0, 12'hEBA, 1'b0);
    pix("p2", 2'b10, 4'd3, 4'd5, 2'b10, 4'd3, 1'b1, 12'h123, 1'b0);

    // contention, one result per cycle, rr_last=1 so P1 first
    req_valid = 2'b11; req_index = {4'd3, 4'd5};
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr.rdy", 16'(req_ready), 16'(exp_g[k]));
      cyc();
      chk("rr.vld", 16'(out_valid), 16'd1);
      chk("rr.id",  16'(out_id), 16'(exp_g[k][1]));
      chk("rr.rgb", 16'(out_rgb), exp_g[k][1] ? 16'h123 : 16'hEBA);
    end

    // stall with P2 result pending
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("st.rdy", 16'(req_ready), 16'd0);
      cyc();
      chk("st.vld", 16'(out_valid), 16'd1);
      chk("st.id",  16'(out_id), 16'd1);
      chk("st.rgb", 16'(out_rgb), 16'h123);
    end
    out_ready = 1'b1;
    #1;
    chk("st.resume", 16'(req_ready), 16'b01);
    cyc();
    chk("st.id2", 16'(out_id), 16'd0);
    chk("st.rgb2", 16'(out_rgb), 16'hEBA);
    req_valid = 2'b00;
    cyc();
    chk("idle.vld", 16'(out_valid), 16'd0);
    chk("idle.rgb", 16'(out_rgb), 16'hEBA);

    // P2 flash on (24 -> 22), transparency wins, opaque gets flash colour
    flash_start = 2'b10; cyc(); flash_start = 2'b00;
    chk("f2.act", 16'(flash_active), 16'b10);
    tick(2);
    pix("t4", 2'b10, 4'd1, 4'd5, 2'b10, 4'd1, 1'b1, 12'h000, 1'b1);
    pix("f2on", 2'b10, 4'd3, 4'd5, 2'b10, 4'd3, 1'b1, 12'hFFF, 1'b0);

    // P1 flash: 24 off, 22 on, 21 off
    flash_start = 2'b01; cyc(); flash_start = 2'b00;
    chk("f1.act", 16'(flash_active), 16'b11);
    pix("f24", 2'b01, 4'd3, 4'd5, 2'b01, 4'd5, 1'b0, 12'hEBA, 1'b0);
    tick(2);
    pix("f22", 2'b01, 4'd3, 4'd5, 2'b01, 4'd5, 1'b0, 12'hFFF, 1'b0);
    tick(1);
    pix("f21", 2'b01, 4'd3, 4'd5, 2'b01, 4'd5, 1'b0, 12'hEBA, 1'b0);
    tick(19);  // P2 reaches 0 (22-3-19 saturates), P1 at 2
    chk("f.p2end", 16'(flash_active), 16'b01);
    tick(2);
    chk("f.p1end", 16'(flash_active), 16'b00);
    tick(1);
    chk("f.sat", 16'(flash_active), 16'b00);
    flash_start = 2'b01; frame_tick = 1'b1; cyc();
    flash_start = 2'b00; frame_tick = 1'b0;
    chk("f.ldwin", 16'(flash_active), 16'b01);
    pix("f24b", 2'b01, 4'd3, 4'd5, 2'b01, 4'd5, 1'b0, 12'hEBA, 1'b0);
    tick(1);
    pix("f23", 2'b01, 4'd3, 4'd5, 2'b01, 4'd5, 1'b0, 12'hFFF, 1'b0);

    // async reset mid-stream
    req_valid = 2'b10; req_index = {4'd3, 4'd5};
    cyc();
    chk("ar.pre", 16'(out_valid), 16'd1);
    #2 Reset_n = 1'b0;
    #1;
    chk("ar.vld", 16'(out_valid), 16'd0);
    chk("ar.fa",  16'(flash_active), 16'b00);
    chk("ar.rgb", 16'(out_rgb), 16'h000);
    #1 Reset_n = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("ar.rr", 16'(req_ready), 16'b01);
    cyc();
    chk("ar.id", 16'(out_id), 16'd0);
    req_valid = 2'b00;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/palette_share_arbiter.md
Name: palette_share_arbiter

Overview:
- Shares one combinational 16-entry, 12-bit character palette ROM (4-bit index in, {R,G,B} 4 bits each out) between two fighter sprite pixel pipelines: P1 is id 0, P2 is id 1.
- Arbitrates per-pixel lookup requests round-robin and registers the looked-up colour.
- Flags the transparency key colour.
- Applies a per-player hit-flash effect, counted in frames, before the colour reaches the VGA compositor.

Parameters:
- TRANSP_IDX, 4'd1: palette index treated as transparent (the magenta key).
- FLASH_FRAMES, 6'd24: frames a hit flash lasts after a trigger.
- FLASH_COLOR, 12'hFFF: colour substituted for opaque pixels during the flash "on" phase.

Ports:
- Clk, in, 1: system clock.
- Reset_n, in, 1: asynchronous active-low reset.
- req_valid, in, 2: per-requester lookup request, bit i = requester i.
- req_index, in, 8: {idx1[3:0], idx0[3:0]}, palette index per requester.
- req_ready, out, 2: per-requester grant; a transfer occurs when req_valid[i] && req_ready[i].
- pal_index, out, 4: index driven to the shared palette ROM.
- pal_rgb, in, 12: ROM output {red, green, blue}, combinational from pal_index.
- out_valid, out, 1: registered result valid.
- out_ready, in, 1: compositor accepts the result.
- out_id, out, 1: requester that owns the current result.
- out_rgb, out, 12: final colour.
- out_transparent, out, 1: result index equalled TRANSP_IDX.
- frame_tick, in, 1: one-cycle pulse per frame (vsync edge).
- flash_start, in, 2: one-cycle pulse per player to start or retrigger a flash.
- flash_active, out, 2: per-player flash counter nonzero.

Behaviour:
- Reset values (Reset_n low, asynchronous):
  - out_valid=0, out_id=0, out_rgb=0, out_transparent=0.
  - Flash counters=0, flash_active=0.
  - rr_last=1, so P1 wins the first contention.
- Stall condition: stall = out_valid && !out_ready. While stalled:
  - req_ready = 2'b00.
  - All output registers hold.
- Grant (combinational, when not stalled):
  - Only one req_valid bit set: grant that requester.
  - Both set: grant the requester != rr_last.
  - req_ready is one-hot or zero.
  - req_ready never depends on out_ready except through stall.
- ROM drive: pal_index = index of the granted requester. With no grant, pal_index = idx0 (don't-care, stable).
- Latency: a transfer in cycle N produces out_valid=1 in cycle N+1, with out_id = granted id and the rgb computed from pal_rgb sampled in cycle N.
- rr_last updates to the granted id on every transfer.
- Output register update, on a cycle with no stall:
  - Transfer occurred: load the new result.
  - No transfer: out_valid clears to 0 and the data fields hold.
  - Throughput is one pixel per cycle with out_ready held high.
- Colour rule, on the registered path:
  - index == TRANSP_IDX: out_transparent=1, out_rgb=12'h000, flash ignored.
  - Else if flash_on[id]: out_rgb = FLASH_COLOR.
  - Else: out_rgb = pal_rgb.
- Flash counter, one 6-bit counter per player:
  - flash_start[i]: load FLASH_FRAMES.
  - Else frame_tick && cnt != 0: decrement by 1.
  - flash_start and frame_tick in the same cycle: the load wins.
  - Retrigger while active reloads; the counts do not accumulate.
  - The counter saturates at 0 and never wraps.
- Flash outputs:
  - flash_active[i] = (cnt_i != 0).
  - flash_on[i] = flash_active[i] && cnt_i[1], a blink of 2 frames on, 2 frames off.
- Flash/pixel timing: flash_on is sampled in the same cycle as the grant, so a counter change becomes visible on the next granted pixel.
- Reset mid-operation: in-flight result discarded, out_valid drops immediately, counters cleared.
- Arbitration does not depend on index values or flash state.

Test Plan:
1. Reset, then req_valid=2'b01, idx0=4'd5, pal_rgb=12'hEBA, out_ready=1 -> req_ready=01, pal_index=5; next cycle out_valid=1, out_id=0, out_rgb=12'hEBA, out_transparent=0.
2. req_valid=2'b11 held for 4 cycles with out_ready=1 -> grants 01,10,01,10; out_id sequence 0,1,0,1; one result per cycle.
3. Stall: result pending, out_ready=0 for 3 cycles with req_valid=11 -> req_ready=00, out_rgb and out_id frozen; out_ready=1 -> outstanding result accepted, arbitration resumes at the alternate id.
4. idx1=TRANSP_IDX (1), pal_rgb=12'hF0F, flash active on P2 -> out_transparent=1, out_rgb=12'h000.
5. Flash P1: flash_start=01 -> cnt=24, flash_active=01.
   - Opaque index with cnt=24 (bit1=0) -> pal_rgb.
   - After 2 frame_ticks, cnt=22 (bit1=1) -> 12'hFFF.
   - 24 ticks total -> flash_active=00.
   - flash_start and frame_tick in the same cycle -> cnt=24.
6. Async reset asserted mid-stream with out_valid=1 -> out_valid=0, flash_active=00 without a clock edge; first contention after release grants P1.
